// File: rtl/inst_fetch_pkg.sv
// Shared types and default sizing for the instruction fetch sequencer.
package inst_fetch_pkg;

  localparam int WIDTH_DEF     = 9;
  localparam int DEPTH_DEF     = 32;
  localparam int ADDR_BITS_DEF = 5;
  localparam int CNT_BITS_DEF  = 8;

  localparam logic [WIDTH_DEF-1:0] HALT_WORD_DEF = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {inst, pc} holding register absorbing a returning ROM word while the output stage is stalled.
module fetch_skid_buf
  import inst_fetch_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_inst,
  input  logic [ADDR_BITS-1:0] in_pc,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_inst,
  output logic [ADDR_BITS-1:0] out_pc,
  input  logic                 out_ready
);

  logic                 vld_q;
  logic [WIDTH-1:0]     inst_q;
  logic [ADDR_BITS-1:0] pc_q;

  assign in_ready  = !vld_q || out_ready;
  assign out_valid = vld_q;
  assign out_inst  = inst_q;
  assign out_pc    = pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
    end else if (flush) begin
      vld_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      vld_q <= 1'b1;
    end else if (out_ready) begin
      vld_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      inst_q <= in_inst;
      pc_q   <= in_pc;
    end
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, tracks the in-flight ROM read, streams words via valid/ready.
// Define FETCH_WRAP_EN to let the PC wrap to 0 after the last ROM word instead of stopping.
module inst_fetch_ctrl
  import inst_fetch_pkg::*;
#(
  parameter int               WIDTH     = WIDTH_DEF,
  parameter int               DEPTH     = DEPTH_DEF,
  parameter int               ADDR_BITS = ADDR_BITS_DEF,
  parameter logic [WIDTH-1:0] HALT_WORD = {WIDTH{HALT_WORD_DEF[0]}},
  parameter int               CNT_BITS  = CNT_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [ADDR_BITS-1:0] rom_addr,
  input  logic [WIDTH-1:0]     rom_data,
  output logic [WIDTH-1:0]     inst,
  output logic [ADDR_BITS-1:0] inst_pc,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  input  logic                 br_valid,
  input  logic [ADDR_BITS-1:0] br_target,
  output logic                 halted,
  output logic [CNT_BITS-1:0]  retired
);

  localparam logic [ADDR_BITS-1:0] LAST_PC = ADDR_BITS'(DEPTH - 1);
`ifdef FETCH_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  fetch_state_e state_q, state_d;

  logic [ADDR_BITS-1:0] pc_q;
  logic                 vld_p0;
  logic [ADDR_BITS-1:0] pc_p0;
  logic                 vld_p1;
  logic [WIDTH-1:0]     inst_p1;
  logic [ADDR_BITS-1:0] pc_p1;
  logic [CNT_BITS-1:0]  retired_q;

  logic                 skid_vld, skid_in_vld, skid_in_rdy;
  logic [WIDTH-1:0]     skid_inst;
  logic [ADDR_BITS-1:0] skid_pc;

  logic active, redirect, start_go, accept, out_free, halt_hit, issue, at_end;

  function automatic logic [ADDR_BITS-1:0] clamp_pc(input logic [ADDR_BITS-1:0] t);
    if (int'(t) >= DEPTH) return LAST_PC;
    return t;
  endfunction

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c);
    if (c == '1) return c;
    return c + 1'b1;
  endfunction

  assign active   = (state_q == RUN) || (state_q == DRAIN);
  assign redirect = br_valid && active;
  assign start_go = start && ((state_q == IDLE) || (state_q == HALT));
  assign accept   = vld_p1 && inst_ready;
  assign out_free = !vld_p1 || inst_ready;
  assign halt_hit = vld_p0 && (rom_data == HALT_WORD);

  // A returning word goes to the skid when the output is busy, or behind an older skid entry.
  assign skid_in_vld = vld_p0 && !redirect && (!out_free || skid_vld);
  // Issue only if the skid is guaranteed empty after this edge, so the next return always has a home.
  assign issue  = (state_q == RUN) && !redirect && !halt_hit && !skid_in_vld && skid_in_rdy;
  assign at_end = issue && (pc_q == LAST_PC) && !WRAP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (!redirect && (halt_hit || at_end)) state_d = DRAIN;
      DRAIN: begin
        if (redirect)                               state_d = RUN;
        else if (!vld_p0 && !vld_p1 && !skid_vld)   state_d = HALT;
      end
      HALT:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: address issued to the ROM, word returns on the next edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= '0;
      vld_p0 <= 1'b0;
    end else if (redirect) begin
      pc_q   <= clamp_pc(br_target);
      vld_p0 <= 1'b0;
    end else if (start_go) begin
      pc_q   <= '0;
      vld_p0 <= 1'b0;
    end else if (halt_hit) begin
      pc_q   <= pc_p0;
      vld_p0 <= 1'b0;
    end else if (issue) begin
      vld_p0 <= 1'b1;
      pc_q   <= (pc_q == LAST_PC) ? (WRAP ? '0 : pc_q) : pc_q + 1'b1;
    end else begin
      vld_p0 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) pc_p0 <= pc_q;
  end

  fetch_skid_buf #(
    .WIDTH     (WIDTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .in_valid  (skid_in_vld),
    .in_inst   (rom_data),
    .in_pc     (pc_p0),
    .in_ready  (skid_in_rdy),
    .out_valid (skid_vld),
    .out_inst  (skid_inst),
    .out_pc    (skid_pc),
    .out_ready (out_free)
  );

  // Stage p1: output register presented to the decoder
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      inst_p1 <= '0;
      pc_p1   <= '0;
    end else if (redirect) begin
      vld_p1 <= 1'b0;
    end else if (out_free) begin
      if (skid_vld) begin
        vld_p1  <= 1'b1;
        inst_p1 <= skid_inst;
        pc_p1   <= skid_pc;
      end else if (vld_p0) begin
        vld_p1  <= 1'b1;
        inst_p1 <= rom_data;
        pc_p1   <= pc_p0;
      end else begin
        vld_p1 <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        retired_q <= '0;
    else if (start_go) retired_q <= '0;
    else if (accept)   retired_q <= sat_inc(retired_q);
  end

  assign rom_addr   = pc_q;
  assign inst       = inst_p1;
  assign inst_pc    = pc_p1;
  assign inst_valid = vld_p1;
  assign halted     = (state_q == HALT);
  assign retired    = retired_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl with a behavioural 32x9 registered-read ROM.
module tb_inst_fetch_ctrl;

`ifdef FETCH_WRAP_EN
  localparam int T3_CNT = 18;
  localparam int T3_RET = 20;
`else
  localparam int T3_CNT = 12;
  localparam int T3_RET = 14;
`endif

  logic       clk = 1'b0;
  logic       rst_n, start, inst_ready, br_valid;
  logic [4:0] br_target, rom_addr, inst_pc;
  logic [8:0] rom_data, inst;
  logic       inst_valid, halted;
  logic [7:0] retired;
  logic [8:0] rom [32];

  int         nvec = 0;
  int         nerr = 0;
  int         exp_pc, cnt;
  logic       stalled;
  logic [4:0] hold_pc;
  logic [8:0] hold_inst;
  logic       pat [4];

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  inst_fetch_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .br_valid   (br_valid),
    .br_target  (br_target),
    .halted     (halted),
    .retired    (retired)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; inst_ready = 1'b1; br_valid = 1'b0; br_target = '0;
    for (int i = 0; i < 32; i++) rom[i] = 9'h040 + 9'(i);
    rom[5] = 9'h1FF;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    #12;
    chk("rst_valid", 32'(inst_valid), 0);
    chk("rst_inst", 32'(inst), 0);
    chk("rst_pc", 32'(inst_pc), 0);
    chk("rst_addr", 32'(rom_addr), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_retired", 32'(retired), 0);
    rst_n = 1'b1;
    step();

    // Straight-line program ending in the halt word, decoder always ready
    start = 1'b1; step(); start = 1'b0;
    chk("t1_addr_e0", 32'(rom_addr), 0);
    chk("t1_valid_e0", 32'(inst_valid), 0);
    step();
    chk("t1_valid_e1", 32'(inst_valid), 0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t1_valid", 32'(inst_valid), 1);
      chk("t1_pc", 32'(inst_pc), 32'(i));
      chk("t1_inst", 32'(inst), 32'(rom[i]));
    end
    for (int k = 0; k < 10 && !halted; k++) step();
    chk("t1_halted", 32'(halted), 1);
    chk("t1_retired", 32'(retired), 6);
    chk("t1_addr_stop", 32'(rom_addr), 5);
    chk("t1_valid_off", 32'(inst_valid), 0);

    // Redirect while halted is ignored
    br_valid = 1'b1; br_target = 5'd10; step(); br_valid = 1'b0;
    chk("t6_br_halted", 32'(halted), 1);
    chk("t6_br_addr", 32'(rom_addr), 5);
    chk("t6_br_valid", 32'(inst_valid), 0);

    // Restart from HALT with back-pressure 1,0,0,1 from cycle 3
    start = 1'b1; step(); start = 1'b0;
    chk("t6_retired_clr", 32'(retired), 0);
    chk("t6_run", 32'(halted), 0);
    chk("t6_addr0", 32'(rom_addr), 0);
    exp_pc = 0; stalled = 1'b0; hold_pc = '0; hold_inst = '0;
    for (int k = 1; k <= 20; k++) begin
      inst_ready = (k < 3) ? 1'b1 : pat[(k - 3) % 4];
      if (stalled) begin
        chk("t2_hold_pc", 32'(inst_pc), 32'(hold_pc));
        chk("t2_hold_inst", 32'(inst), 32'(hold_inst));
      end
      if (inst_valid && inst_ready) begin
        chk("t2_pc", 32'(inst_pc), 32'(exp_pc));
        chk("t2_inst", 32'(inst), 32'(rom[exp_pc]));
        exp_pc++;
      end
      stalled = inst_valid && !inst_ready; hold_pc = inst_pc; hold_inst = inst;
      step();
      if (k == 4 || k == 5) chk("t2_pc_stall", 32'(rom_addr), 3);
    end
    inst_ready = 1'b1;
    chk("t2_count", 32'(exp_pc), 6);
    chk("t2_retired", 32'(retired), 6);
    chk("t2_halted", 32'(halted), 1);

    // Redirect to 20 while pc 2 sits unaccepted
    start = 1'b1; step(); start = 1'b0;
    step(); step(); step(); step();
    chk("t3_pre_valid", 32'(inst_valid), 1);
    chk("t3_pre_pc", 32'(inst_pc), 2);
    inst_ready = 1'b0; br_valid = 1'b1; br_target = 5'd20;
    step();
    br_valid = 1'b0; inst_ready = 1'b1;
    chk("t3_flush_valid", 32'(inst_valid), 0);
    chk("t3_addr", 32'(rom_addr), 20);
    chk("t3_retired", 32'(retired), 2);
    step();
    chk("t3_valid_r1", 32'(inst_valid), 0);
    step();
    chk("t3_valid_r2", 32'(inst_valid), 1);
    chk("t3_pc_r2", 32'(inst_pc), 20);
    chk("t3_inst_r2", 32'(inst), 32'(rom[20]));
    exp_pc = 20; cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (inst_valid && inst_ready) begin
        chk("t3_pc", 32'(inst_pc), 32'(exp_pc));
        exp_pc = (exp_pc + 1) % 32; cnt++;
      end
      step();
    end
    chk("t3_count", 32'(cnt), 32'(T3_CNT));
    chk("t3_retired_end", 32'(retired), 32'(T3_RET));
    chk("t3_halted", 32'(halted), 1);

    // No halt word in ROM: run off the end of memory
    rom[5] = 9'h045;
    start = 1'b1; step(); start = 1'b0;
    exp_pc = 0; cnt = 0;
    for (int k = 1; k <= 45; k++) begin
      start = (k == 10);
      if (inst_valid && inst_ready) begin
        chk("t4_pc", 32'(inst_pc), 32'(exp_pc));
        chk("t4_inst", 32'(inst), 32'(rom[exp_pc]));
        exp_pc = (exp_pc + 1) % 32; cnt++;
      end
      step();
    end
    start = 1'b0;
`ifdef FETCH_WRAP_EN
    chk("t4_wrapped", 32'(cnt > 32), 1);
    chk("t4_halted", 32'(halted), 0);
`else
    chk("t4_count", 32'(cnt), 32);
    chk("t4_retired", 32'(retired), 32);
    chk("t4_halted", 32'(halted), 1);
    chk("t4_addr_end", 32'(rom_addr), 31);
`endif

    // Asynchronous reset mid-stream, off the clock edge
    start = 1'b1; step(); start = 1'b0;
    step(); step(); step();
    #2; rst_n = 1'b0; #1;
    chk("t5_valid", 32'(inst_valid), 0);
    chk("t5_inst", 32'(inst), 0);
    chk("t5_pc", 32'(inst_pc), 0);
    chk("t5_addr", 32'(rom_addr), 0);
    chk("t5_retired", 32'(retired), 0);
    chk("t5_halted", 32'(halted), 0);
    #4; rst_n = 1'b1;
    step();
    chk("t5_idle_valid", 32'(inst_valid), 0);
    start = 1'b1; step(); start = 1'b0;
    step();
    chk("t5_valid_e1", 32'(inst_valid), 0);
    step();
    chk("t5_valid_e2", 32'(inst_valid), 1);
    chk("t5_pc_e2", 32'(inst_pc), 0);
    chk("t5_inst_e2", 32'(inst), 32'(rom[0]));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
Fetch sequencer for the synchronous instruction ROM (9-bit words, 32 deep, 1-cycle registered read) in the lab CPU. Owns the program counter and drives the ROM address. Tracks the in-flight read and streams instructions to the decoder over a valid/ready handshake, with a 1-entry skid buffer. Handles branch redirect/flush, halt-word detection, end-of-memory stop, and an accepted-instruction counter.

Parameters:
WIDTH, 9, instruction word width; must match the ROM width.
DEPTH, 32, ROM word count.
ADDR_BITS, 5, PC/address width; DEPTH <= 2**ADDR_BITS.
HALT_WORD, all ones ({WIDTH{1'b1}}), instruction encoding that halts fetch.
CNT_BITS, 8, width of the retired-instruction counter.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begin fetch from address 0 (IDLE/HALT only)
rom_addr  out  ADDR_BITS  to ROM ADDRESS
rom_data  in  WIDTH  from ROM DATAOUT; valid 1 cycle after address
inst  out  WIDTH  instruction to decoder
inst_pc  out  ADDR_BITS  address of inst
inst_valid  out  1  inst/inst_pc valid
inst_ready  in  1  decoder accepts when valid&&ready at posedge
br_valid  in  1  redirect request
br_target  in  ADDR_BITS  redirect address
halted  out  1  high in HALT state
retired  out  CNT_BITS  count of accepted instructions, saturating

Behaviour:
- Reset (async, rst_n=0): state IDLE, pc=0, rom_addr=0, inst=0, inst_pc=0, inst_valid=0, halted=0, retired=0; inflight and skid flags cleared.
- States and transitions:
  - IDLE -> RUN on start.
  - RUN -> DRAIN when the halt word or the end of memory is reached.
  - DRAIN -> HALT once the output stage and skid are empty.
  - HALT -> RUN on start; this clears retired and sets pc=0.
- rom_addr = pc_q (registered). In RUN, an issue occurs in each cycle the skid is empty: inflight<=1, inflight_pc<=pc, pc<=pc+1.
- Latency: start sampled at edge E0; address 0 presented after E0; ROM captures at E1; inst_valid=1 after E2.
- Sustained throughput is 1 instruction/cycle while inst_ready=1.
- Return path: the inflight word loads the output register if it is empty or being accepted that cycle; otherwise it loads the skid.
- When the skid is full, issue stalls (pc held), so nothing is ever lost.
- While inst_valid=1 && inst_ready=0, inst and inst_pc are held stable.
- Redirect: br_valid in RUN/DRAIN at an edge sets pc<=br_target and state RUN, and flushes the inflight word, the skid, and any unaccepted output (inst_valid=0 next cycle).
- An instruction accepted on the same edge as br_valid counts as accepted; the flush applies afterwards.
- First redirected instruction: inst_valid=1 two cycles after the redirect edge.
- br_valid in IDLE/HALT is ignored.
- br_target >= DEPTH: clamp to DEPTH-1.
- Halt word: when a returning word equals HALT_WORD, it is delivered normally but no further issues occur, and later inflight data is discarded.
- End of memory: after issuing address DEPTH-1, stop issuing and enter DRAIN. pc does not wrap; no address >= DEPTH is ever driven.
- retired increments on each valid&&ready and saturates at all ones.
- start in RUN/DRAIN is ignored.
- rst_n asserted mid-operation returns everything to reset values immediately; any inflight ROM data is dropped.

Optional Feature:
FETCH_WRAP_EN
- Defined: after issuing DEPTH-1, pc wraps to 0 and fetch continues. Only HALT_WORD or a redirect stops or alters the stream.
- Undefined: end-of-memory stop as above.

Decomposition:
- Package inst_fetch_pkg: fetch_state_e enum (IDLE, RUN, DRAIN, HALT), the default WIDTH/ADDR_BITS/DEPTH constants, and the HALT_WORD default.
- Natural sub-module: fetch_skid_buf, a 1-entry {inst,pc} holding register with valid/ready in and out.
- Top-level controller: FSM, pc, inflight tracking.

Test Plan:
- ROM with 0..4 as NOPs and 5 = 9'h1FF, inst_ready=1, pulse start: inst_pc 0..5 on consecutive cycles from E2; then halted=1, retired=6, rom_addr stops at 5.
- Same ROM, inst_ready toggling 1,0,0,1 from cycle 3: every pc delivered exactly once and in order; inst/inst_pc stable while stalled; skid fills and pc holds.
- br_valid with br_target=20 while inst_pc=2 is unaccepted: pc 2 dropped; next inst_pc=20 two cycles after the redirect; retired excludes 2.
- ROM with no halt word, inst_ready=1: delivers 0..31, then halted=1, retired=32. With FETCH_WRAP_EN: inst_pc 31 is followed by 0 and halted stays 0.
- rst_n pulsed low for a non-edge-aligned half cycle mid-stream: outputs zero immediately. After release, start restarts at pc 0 with first inst_valid at E2.
- br_valid and start asserted in HALT: both br_valid ignored; start resumes at 0 and retired clears to 0.
